// File: rtl/pipeline_pkg.sv
// Shared definitions for the pipeline sequencer.
// Contents: stage indices, controller state encoding, register-number width,
// and the packed EX-stage shadow payload.
package pipeline_pkg;

  // Buffer / stage indices into buf_en and stage_valid
  localparam int unsigned ST_IFID  = 0;
  localparam int unsigned ST_IDEX  = 1;
  localparam int unsigned ST_EXMEM = 2;
  localparam int unsigned ST_MEMWB = 3;

  localparam int unsigned NUM_STAGES = 4;
  localparam int unsigned REG_W      = 4;

  // Width of the memory-wait counter; covers MEM_WAIT_MAX up to 65535
  localparam int unsigned WAIT_W = 16;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    TIMEOUT  = 2'd2
  } ctrl_state_t;

  // Copy of the ID-stage destination info for the instruction now in EX
  typedef struct packed {
    logic [REG_W-1:0] rd;
    logic             rd_we;
    logic             is_load;
  } ex_shadow_t;

endpackage

// File: rtl/pipe_hazard_detect.sv
// Combinational load-use hazard detector.
// Ports:
//   id_valid, ex_valid          stage_valid of IF/ID and ID/EX buffers
//   id_rs_a/id_rs_b (+ _used)   source registers read by the ID instruction
//   ex_rd, ex_rd_we, ex_is_load shadow of the instruction now in EX
//   lu_c                        ID needs a value the EX load has not produced yet
module pipe_hazard_detect
  import pipeline_pkg::*;
(
  input  logic             id_valid,
  input  logic             ex_valid,
  input  logic [REG_W-1:0] id_rs_a,
  input  logic             id_rs_a_used,
  input  logic [REG_W-1:0] id_rs_b,
  input  logic             id_rs_b_used,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_rd_we,
  input  logic             ex_is_load,
  output logic             lu_c
);

  logic match_a;
  logic match_b;

  // Source-operand compares against the EX load's destination
  always_comb begin
    match_a = id_rs_a_used & (id_rs_a == ex_rd);
    match_b = id_rs_b_used & (id_rs_b == ex_rd);
    lu_c    = id_valid & ex_valid & ex_is_load & ex_rd_we & (match_a | match_b);
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline sequencer for the IF/ID, ID/EX, EX/MEM and MEM/WB buffers.
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   fetch_valid       instruction memory returned a word this cycle
//   id_*              source/destination info of the instruction in ID
//   ex_branch_taken   EX redirects the PC this cycle
//   mem_busy          data memory not ready for the instruction in MEM
//   pc_en, buf_en     same-cycle load enables (gated low while in reset)
//   stage_valid       registered valid bit per buffer
//   mem_timeout       sticky flag: memory wait exceeded MEM_WAIT_MAX
//   stall_cycles      saturating count of cycles with pc_en low
module pipeline_ctrl
  import pipeline_pkg::*;
#(
  parameter int unsigned MEM_WAIT_MAX = 255,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             fetch_valid,
  input  logic [REG_W-1:0] id_rs_a,
  input  logic [REG_W-1:0] id_rs_b,
  input  logic             id_rs_a_used,
  input  logic             id_rs_b_used,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_rd_we,
  input  logic             id_is_load,
  input  logic             ex_branch_taken,
  input  logic             mem_busy,
  output logic             pc_en,
  output logic [3:0]       buf_en,
  output logic [3:0]       stage_valid,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cycles
);

  ctrl_state_t       state;
  ctrl_state_t       state_nxt;
  ex_shadow_t        shadow;
  ex_shadow_t        shadow_nxt;
  logic [3:0]        valid_nxt;
  logic [WAIT_W-1:0] wait_cnt;
  logic [WAIT_W-1:0] wait_nxt;
  logic              pc_en_raw;
  logic [3:0]        buf_en_raw;
  logic              run_rules;
  logic              mb;
  logic              br;
  logic              lu;

  // Qualified events
  assign mb = mem_busy & stage_valid[ST_EXMEM];
  assign br = ex_branch_taken & stage_valid[ST_IDEX];

  pipe_hazard_detect u_hazard (
    .id_valid     (stage_valid[ST_IFID]),
    .ex_valid     (stage_valid[ST_IDEX]),
    .id_rs_a      (id_rs_a),
    .id_rs_a_used (id_rs_a_used),
    .id_rs_b      (id_rs_b),
    .id_rs_b_used (id_rs_b_used),
    .ex_rd        (shadow.rd),
    .ex_rd_we     (shadow.rd_we),
    .ex_is_load   (shadow.is_load),
    .lu_c         (lu)
  );

  // State register, valid shift register, EX shadow, wait counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= RUN;
      stage_valid <= '0;
      shadow      <= '0;
      wait_cnt    <= '0;
    end else begin
      state       <= state_nxt;
      stage_valid <= valid_nxt;
      shadow      <= shadow_nxt;
      wait_cnt    <= wait_nxt;
    end
  end

  // Next-state and enable logic
  always_comb begin
    state_nxt  = state;
    valid_nxt  = stage_valid;
    shadow_nxt = shadow;
    wait_nxt   = wait_cnt;
    pc_en_raw  = 1'b0;
    buf_en_raw = 4'h0;
    run_rules  = 1'b0;

    case (state)
      RUN: begin
        if (mb) begin
          state_nxt = MEM_WAIT;
          wait_nxt  = WAIT_W'(1);
        end else begin
          run_rules = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (mb) begin
          if (wait_cnt == WAIT_W'(MEM_WAIT_MAX)) begin
            state_nxt = TIMEOUT;
          end else begin
            wait_nxt = wait_cnt + WAIT_W'(1);
          end
        end else begin
          // Release: RUN rules apply in this same cycle
          state_nxt = RUN;
          wait_nxt  = '0;
          run_rules = 1'b1;
        end
      end
      TIMEOUT: begin
        state_nxt = TIMEOUT;
      end
      default: begin
        state_nxt = RUN;
      end
    endcase

    if (run_rules) begin
      pc_en_raw  = 1'b1;
      buf_en_raw = 4'hF;
      if (br) begin
        // Squash the two younger instructions; the branch moves on to MEM
        valid_nxt  = {stage_valid[ST_EXMEM], stage_valid[ST_IDEX], 2'b00};
        shadow_nxt = '0;
      end else if (lu) begin
        // Hold PC and IF/ID, inject one bubble into ID/EX
        pc_en_raw  = 1'b0;
        buf_en_raw = 4'hE;
        valid_nxt  = {stage_valid[ST_EXMEM], stage_valid[ST_IDEX], 1'b0,
                      stage_valid[ST_IFID]};
        shadow_nxt = '0;
      end else begin
        valid_nxt  = {stage_valid[ST_EXMEM:ST_IFID], fetch_valid};
        shadow_nxt = '{rd: id_rd, rd_we: id_rd_we, is_load: id_is_load};
      end
    end
  end

  assign pc_en  = rst_n & pc_en_raw;
  assign buf_en = {NUM_STAGES{rst_n}} & buf_en_raw;

  // Sticky timeout flag and saturating stall counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_timeout  <= 1'b0;
      stall_cycles <= '0;
    end else begin
      if (state_nxt == TIMEOUT) begin
        mem_timeout <= 1'b1;
      end
      if (!pc_en && (stall_cycles != {CNT_W{1'b1}})) begin
        stall_cycles <= stall_cycles + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: a reference model pushes expected
// enables and post-edge register values per cycle; they are popped and
// compared after the clock edge.
module tb_pipeline_ctrl;

  localparam int unsigned MAXW = 4;
  localparam int unsigned CW   = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          fetch_valid;
  logic [3:0]    id_rs_a, id_rs_b, id_rd;
  logic          id_rs_a_used, id_rs_b_used, id_rd_we, id_is_load;
  logic          ex_branch_taken, mem_busy;
  logic          pc_en;
  logic [3:0]    buf_en;
  logic [3:0]    stage_valid;
  logic          mem_timeout;
  logic [CW-1:0] stall_cycles;

  pipeline_ctrl #(.MEM_WAIT_MAX(MAXW), .CNT_W(CW)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .fetch_valid     (fetch_valid),
    .id_rs_a         (id_rs_a),
    .id_rs_b         (id_rs_b),
    .id_rs_a_used    (id_rs_a_used),
    .id_rs_b_used    (id_rs_b_used),
    .id_rd           (id_rd),
    .id_rd_we        (id_rd_we),
    .id_is_load      (id_is_load),
    .ex_branch_taken (ex_branch_taken),
    .mem_busy        (mem_busy),
    .pc_en           (pc_en),
    .buf_en          (buf_en),
    .stage_valid     (stage_valid),
    .mem_timeout     (mem_timeout),
    .stall_cycles    (stall_cycles)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          pc;
    logic [3:0]    be;
    logic [3:0]    v;
    logic          to;
    logic [CW-1:0] st;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  // Reference model state
  int         ms;          // 0 run, 1 wait, 2 timeout
  logic [3:0] mv;
  logic [3:0] m_rd;
  logic       m_we, m_ld;
  int         m_wait;
  logic       m_to;
  int         m_stall;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Compute expected same-cycle enables and next register values from inputs
  task automatic model(output exp_t e);
    logic mbq, brq, luq, pc;
    logic [3:0] be;
    mbq = mem_busy & mv[2];
    brq = ex_branch_taken & mv[1];
    luq = mv[0] & mv[1] & m_ld & m_we &
          ((id_rs_a_used && id_rs_a == m_rd) || (id_rs_b_used && id_rs_b == m_rd));
    pc = 1'b0;
    be = 4'h0;
    if (!rst_n) begin
      ms = 0; mv = 4'h0; m_rd = 4'h0; m_we = 1'b0; m_ld = 1'b0;
      m_wait = 0; m_to = 1'b0; m_stall = 0;
    end else begin
      if (ms == 2) begin
        // frozen
      end else if (mbq) begin
        if (ms == 0) begin
          ms = 1; m_wait = 1;
        end else if (m_wait == int'(MAXW)) begin
          ms = 2; m_to = 1'b1;
        end else begin
          m_wait++;
        end
      end else begin
        ms = 0; m_wait = 0;
        if (brq) begin
          pc = 1'b1; be = 4'hF;
          mv = {mv[2], mv[1], 1'b0, 1'b0};
          m_rd = 4'h0; m_we = 1'b0; m_ld = 1'b0;
        end else if (luq) begin
          be = 4'hE;
          mv = {mv[2], mv[1], 1'b0, mv[0]};
          m_rd = 4'h0; m_we = 1'b0; m_ld = 1'b0;
        end else begin
          pc = 1'b1; be = 4'hF;
          mv = {mv[2], mv[1], mv[0], fetch_valid};
          m_rd = id_rd; m_we = id_rd_we; m_ld = id_is_load;
        end
      end
      if (!pc && m_stall < (1 << CW) - 1) m_stall++;
    end
    e.pc = pc; e.be = be; e.v = mv; e.to = m_to; e.st = CW'(m_stall);
  endtask

  // One clock: called just after a negedge with inputs already driven
  task automatic cycle(input string tag);
    exp_t e;
    logic obs_pc;
    logic [3:0] obs_be;
    #1;
    model(e);
    sb.push_back(e);
    obs_pc = pc_en;
    obs_be = buf_en;
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk({tag, ".pc_en"}, 16'(obs_pc), 16'(e.pc));
    chk({tag, ".buf_en"}, 16'(obs_be), 16'(e.be));
    chk({tag, ".stage_valid"}, 16'(stage_valid), 16'(e.v));
    chk({tag, ".mem_timeout"}, 16'(mem_timeout), 16'(e.to));
    chk({tag, ".stall_cycles"}, 16'(stall_cycles), 16'(e.st));
    @(negedge clk);
  endtask

  task automatic idle();
    fetch_valid = 1'b1;
    id_rs_a = 4'h0; id_rs_b = 4'h0; id_rs_a_used = 1'b0; id_rs_b_used = 1'b0;
    id_rd = 4'h0; id_rd_we = 1'b0; id_is_load = 1'b0;
    ex_branch_taken = 1'b0; mem_busy = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cycle("reset");
    rst_n = 1'b1;
  endtask

  task automatic fill();
    idle();
    repeat (4) cycle("fill");
  endtask

  initial begin
    logic [3:0] fill_exp [4];
    fill_exp = '{4'h1, 4'h3, 4'h7, 4'hF};
    rst_n = 1'b0;
    idle();
    ms = 0; mv = 4'h0; m_rd = 4'h0; m_we = 1'b0; m_ld = 1'b0;
    m_wait = 0; m_to = 1'b0; m_stall = 0;
    @(negedge clk);
    do_reset();
    chk("reset.valid", 16'(stage_valid), 16'h0);
    chk("reset.stall", 16'(stall_cycles), 16'h0);

    // 1: fill sequence
    for (int i = 0; i < 4; i++) begin
      cycle("t1");
      chk("t1.fill", 16'(stage_valid), 16'(fill_exp[i]));
    end

    // 2: load-use via rs_a, then unused rs_a, then rs_b
    id_rd = 4'd3; id_rd_we = 1'b1; id_is_load = 1'b1;
    cycle("t2.load");
    idle(); id_rs_a = 4'd3; id_rs_a_used = 1'b1;
    cycle("t2.lu");
    chk("t2.bubble", 16'(stage_valid), 16'hD);
    chk("t2.stall1", 16'(stall_cycles), 16'h1);
    cycle("t2.after");
    idle(); id_rd = 4'd3; id_rd_we = 1'b1; id_is_load = 1'b1;
    cycle("t2.load2");
    idle(); id_rs_a = 4'd3; id_rs_a_used = 1'b0;
    cycle("t2.nolu");
    chk("t2.nostall", 16'(stall_cycles), 16'h1);
    idle(); id_rd = 4'd7; id_rd_we = 1'b1; id_is_load = 1'b1;
    cycle("t2.load3");
    idle(); id_rs_b = 4'd7; id_rs_b_used = 1'b1;
    cycle("t2.lub");
    chk("t2.stall2", 16'(stall_cycles), 16'h2);
    idle(); cycle("t2.tail");

    // 3: taken branch, then branch together with load-use
    fill();
    ex_branch_taken = 1'b1;
    cycle("t3.br");
    chk("t3.squash", 16'(stage_valid), 16'hC);
    idle(); fill();
    id_rd = 4'd2; id_rd_we = 1'b1; id_is_load = 1'b1;
    cycle("t3.load");
    idle(); ex_branch_taken = 1'b1; id_rs_a = 4'd2; id_rs_a_used = 1'b1;
    cycle("t3.brlu");
    chk("t3.brlu.stall", 16'(stall_cycles), 16'h2);
    idle(); cycle("t3.tail");

    // 4: mem_busy ignored with v2=0, then a 3-cycle memory wait
    do_reset();
    mem_busy = 1'b1;
    cycle("t4.ignored");
    idle(); fill();
    mem_busy = 1'b1;
    repeat (3) cycle("t4.busy");
    chk("t4.frozen", 16'(stage_valid), 16'hF);
    mem_busy = 1'b0;
    cycle("t4.resume");
    chk("t4.stall3", 16'(stall_cycles), 16'h3);

    // 5: stuck memory -> timeout, sticky, stall counter saturates
    do_reset();
    fill();
    mem_busy = 1'b1;
    repeat (MAXW + 1) cycle("t5.busy");
    chk("t5.timeout", 16'(mem_timeout), 16'h1);
    mem_busy = 1'b0;
    repeat (16) cycle("t5.held");
    chk("t5.sticky", 16'(mem_timeout), 16'h1);
    chk("t5.saturate", 16'(stall_cycles), 16'hF);
    do_reset();
    chk("t5.cleared", 16'(mem_timeout), 16'h0);

    // 6: reset asserted during MEM_WAIT
    fill();
    mem_busy = 1'b1;
    repeat (2) cycle("t6.busy");
    rst_n = 1'b0;
    cycle("t6.rst");
    chk("t6.valid", 16'(stage_valid), 16'h0);
    chk("t6.stall", 16'(stall_cycles), 16'h0);
    rst_n = 1'b1;
    cycle("t6.run");

    // Random mix against the model
    for (int i = 0; i < 300; i++) begin
      rst_n = ($urandom_range(0, 59) != 0);
      fetch_valid = 1'($urandom_range(0, 3) != 0);
      id_rs_a = 4'($urandom_range(0, 3));
      id_rs_b = 4'($urandom_range(0, 3));
      id_rs_a_used = 1'($urandom_range(0, 1));
      id_rs_b_used = 1'($urandom_range(0, 1));
      id_rd = 4'($urandom_range(0, 3));
      id_rd_we = 1'($urandom_range(0, 3) != 0);
      id_is_load = 1'($urandom_range(0, 1));
      ex_branch_taken = 1'($urandom_range(0, 5) == 0);
      mem_busy = 1'($urandom_range(0, 4) == 0);
      cycle("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
